// File: rtl/ir_pkg.sv
// Shared definitions for the IR pulse path: sample width, peak-tracker state
// encoding and a saturating-add helper.
package ir_pkg;

    localparam int DATA_W = 20;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RISE = 2'd1;
    localparam state_t S_FALL = 2'd2;

    // Returns a + b clamped to lim; the 33-bit sum cannot wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/ir_beat_counter.sv
// Counts enabled samples between detected peaks, enforces the refractory window
// and flags loss of pulse when no peak has been accepted for too long.
module ir_beat_counter #(
    parameter int          CNT_W      = 16,
    parameter int unsigned MIN_PERIOD = 100,
    parameter int unsigned MAX_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             detect,
    output logic             beat_valid,
    output logic [CNT_W-1:0] beat_period,
    output logic             no_pulse
);
    import ir_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_plus1;
    logic [CNT_W-1:0] cnt_inc;
    logic             have_prev;
    logic             accept;
    logic             timeout;

    // have_prev is only set while cnt < MAX_PERIOD, so cnt + 1 never wraps here.
    assign cnt_plus1 = cnt + 1'b1;
    assign cnt_inc   = CNT_W'(sat_add(32'(cnt), 32'd1, MAX_PERIOD));
    assign accept    = have_prev && (32'(cnt_plus1) >= MIN_PERIOD);
    assign timeout   = (32'(cnt_inc) == MAX_PERIOD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            have_prev   <= 1'b0;
            beat_valid  <= 1'b0;
            beat_period <= '0;
            no_pulse    <= 1'b0;
        end else begin
            beat_valid <= 1'b0;
            if (sample_en) begin
                if (detect && !have_prev) begin
                    cnt       <= '0;
                    have_prev <= 1'b1;
                end else if (detect && accept) begin
                    beat_period <= cnt_plus1;
                    beat_valid  <= 1'b1;
                    cnt         <= '0;
                    no_pulse    <= 1'b0;
                end else begin
                    // Plain samples and rejected (too early) peaks both keep counting.
                    cnt <= cnt_inc;
                    if (timeout) begin
                        no_pulse  <= 1'b1;
                        have_prev <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ir_peak_detector.sv
// Hysteresis max/min peak tracker on the filtered IR stream; peak strobes feed
// the beat counter which reports beat period and loss of pulse.
module ir_peak_detector #(
    parameter int          DATA_W     = ir_pkg::DATA_W,
    parameter int          CNT_W      = 16,
    parameter int unsigned HYST       = 512,
    parameter int unsigned MIN_PERIOD = 100,
    parameter int unsigned MAX_PERIOD = 1000
) (
    input  logic              CLK_Filter,
    input  logic              rst_n,
    input  logic              Sample_En,
    input  logic [DATA_W-1:0] In_IR_Filtered,
    output logic              Beat_Valid,
    output logic [CNT_W-1:0]  Beat_Period,
    output logic              Peak_Pulse,
    output logic              No_Pulse
);
    import ir_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W:0]   fall_diff;
    logic [DATA_W-1:0] fall_thresh;
    logic [DATA_W-1:0] rise_thresh;
    logic              fall_hit;
    logic              rise_hit;
    logic              detect;

    // Extra MSB catches max < HYST; the threshold then clamps to 0 instead of wrapping.
    assign fall_diff   = {1'b0, max_q} - (DATA_W + 1)'(HYST);
    assign fall_thresh = fall_diff[DATA_W] ? '0 : fall_diff[DATA_W-1:0];
    assign rise_thresh = DATA_W'(sat_add(32'(min_q), HYST, 32'({DATA_W{1'b1}})));
    assign fall_hit    = In_IR_Filtered < fall_thresh;
    assign rise_hit    = In_IR_Filtered > rise_thresh;

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (Sample_En) begin
            case (state)
                S_IDLE:  state_next = S_RISE;
                S_RISE:  if (fall_hit) state_next = S_FALL;
                S_FALL:  if (rise_hit) state_next = S_RISE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        detect = Sample_En && (state == S_RISE) && fall_hit;
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            max_q      <= '0;
            min_q      <= '0;
            Peak_Pulse <= 1'b0;
        end else begin
            Peak_Pulse <= detect;
            if (Sample_En) begin
                case (state)
                    S_IDLE: begin
                        max_q <= In_IR_Filtered;
                        min_q <= In_IR_Filtered;
                    end
                    S_RISE: begin
                        if (In_IR_Filtered > max_q) max_q <= In_IR_Filtered;
                        else if (fall_hit)          min_q <= In_IR_Filtered;
                    end
                    S_FALL: begin
                        if (In_IR_Filtered < min_q) min_q <= In_IR_Filtered;
                        else if (rise_hit)          max_q <= In_IR_Filtered;
                    end
                    default: ;
                endcase
            end
        end
    end

    ir_beat_counter #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD),
        .MAX_PERIOD (MAX_PERIOD)
    ) u_beat_counter (
        .clk         (CLK_Filter),
        .rst_n       (rst_n),
        .sample_en   (Sample_En),
        .detect      (detect),
        .beat_valid  (Beat_Valid),
        .beat_period (Beat_Period),
        .no_pulse    (No_Pulse)
    );

endmodule

// File: tb/tb_ir_peak_detector.sv
// Directed bench for ir_peak_detector with HYST=10, MIN_PERIOD=4, MAX_PERIOD=20.
module tb_ir_peak_detector;

    localparam int DATA_W = 20;
    localparam int CNT_W  = 16;

    logic              CLK_Filter = 1'b0;
    logic              rst_n      = 1'b0;
    logic              Sample_En  = 1'b0;
    logic [DATA_W-1:0] In_IR_Filtered = '0;
    logic              Beat_Valid;
    logic [CNT_W-1:0]  Beat_Period;
    logic              Peak_Pulse;
    logic              No_Pulse;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] tri_wave [8] = '{20'd0, 20'd25, 20'd50, 20'd75,
                                        20'd100, 20'd75, 20'd50, 20'd25};

    ir_peak_detector #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .HYST       (10),
        .MIN_PERIOD (4),
        .MAX_PERIOD (20)
    ) dut (
        .CLK_Filter     (CLK_Filter),
        .rst_n          (rst_n),
        .Sample_En      (Sample_En),
        .In_IR_Filtered (In_IR_Filtered),
        .Beat_Valid     (Beat_Valid),
        .Beat_Period    (Beat_Period),
        .Peak_Pulse     (Peak_Pulse),
        .No_Pulse       (No_Pulse)
    );

    always #5 CLK_Filter = ~CLK_Filter;

    // Present one enabled sample; outputs are observed 1 time unit after the edge.
    task automatic feed(input logic [DATA_W-1:0] s);
        Sample_En      = 1'b1;
        In_IR_Filtered = s;
        @(posedge CLK_Filter);
        #1;
        Sample_En = 1'b0;
    endtask

    task automatic idle_cycle();
        Sample_En = 1'b0;
        @(posedge CLK_Filter);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        Sample_En = 1'b0;
        repeat (2) @(posedge CLK_Filter);
        #1;
        rst_n = 1'b1;
    endtask

    // 14 triangle samples: first peak at index 5, first accepted beat at index 13.
    task automatic warm_up(input string tag);
        for (int i = 0; i < 14; i++) feed(tri_wave[i % 8]);
        checks++;
        if (Beat_Valid !== 1'b1 || Beat_Period !== 16'd8) begin
            errors++;
            $display("FAIL %s warmup beat: got valid=%b period=%0d expected valid=1 period=8",
                     tag, Beat_Valid, Beat_Period);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge CLK_Filter);
        #1;
        checks++;
        if ({Beat_Valid, Peak_Pulse, No_Pulse} !== 3'b000 || Beat_Period !== 16'd0) begin
            errors++;
            $display("FAIL reset outputs: got valid=%b peak=%b nopulse=%b period=%0d expected all 0",
                     Beat_Valid, Peak_Pulse, No_Pulse, Beat_Period);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_triangle();
        logic exp_peak;
        logic exp_valid;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            feed(tri_wave[i % 8]);
            exp_peak  = (i % 8 == 5);
            exp_valid = exp_peak && (i > 5);
            checks++;
            if (Peak_Pulse !== exp_peak) begin
                errors++;
                $display("FAIL triangle peak i=%0d: got %b expected %b", i, Peak_Pulse, exp_peak);
            end
            checks++;
            if (Beat_Valid !== exp_valid) begin
                errors++;
                $display("FAIL triangle valid i=%0d: got %b expected %b", i, Beat_Valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (Beat_Period !== 16'd8) begin
                    errors++;
                    $display("FAIL triangle period i=%0d: got %0d expected 8", i, Beat_Period);
                end
            end
            checks++;
            if (No_Pulse !== 1'b0) begin
                errors++;
                $display("FAIL triangle no_pulse i=%0d: got %b expected 0", i, No_Pulse);
            end
        end
    endtask

    task automatic test_every_other();
        int cyc = 0;
        int last_valid = -1;
        int n_valid = 0;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            feed(tri_wave[i % 8]);
            cyc++;
            checks++;
            if (Peak_Pulse !== (i % 8 == 5)) begin
                errors++;
                $display("FAIL gapped peak i=%0d: got %b expected %b", i, Peak_Pulse, (i % 8 == 5));
            end
            if (Beat_Valid === 1'b1) begin
                n_valid++;
                checks++;
                if (Beat_Period !== 16'd8) begin
                    errors++;
                    $display("FAIL gapped period i=%0d: got %0d expected 8", i, Beat_Period);
                end
                if (last_valid >= 0) begin
                    checks++;
                    if (cyc - last_valid != 16) begin
                        errors++;
                        $display("FAIL gapped spacing: got %0d cycles expected 16", cyc - last_valid);
                    end
                end
                last_valid = cyc;
            end
            idle_cycle();
            cyc++;
            checks++;
            if (Peak_Pulse !== 1'b0 || Beat_Valid !== 1'b0) begin
                errors++;
                $display("FAIL gapped idle pulses i=%0d: got peak=%b valid=%b expected 0 0",
                         i, Peak_Pulse, Beat_Valid);
            end
        end
        checks++;
        if (n_valid != 3) begin
            errors++;
            $display("FAIL gapped beat count: got %0d expected 3", n_valid);
        end
    endtask

    task automatic test_spurious();
        logic [DATA_W-1:0] seq [8] = '{20'd50, 20'd100, 20'd85, 20'd100,
                                       20'd100, 20'd100, 20'd100, 20'd75};
        logic exp_peak [8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_valid [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        warm_up("spurious");
        for (int i = 0; i < 8; i++) begin
            feed(seq[i]);
            checks++;
            if (Peak_Pulse !== exp_peak[i] || Beat_Valid !== exp_valid[i]) begin
                errors++;
                $display("FAIL spurious step %0d: got peak=%b valid=%b expected peak=%b valid=%b",
                         i, Peak_Pulse, Beat_Valid, exp_peak[i], exp_valid[i]);
            end
        end
        checks++;
        if (Beat_Period !== 16'd8) begin
            errors++;
            $display("FAIL spurious period: got %0d expected 8", Beat_Period);
        end
    endtask

    task automatic test_no_pulse();
        logic exp_np;
        apply_reset();
        warm_up("nopulse");
        for (int k = 0; k < 20; k++) begin
            feed(20'd50);
            exp_np = (k == 19);
            checks++;
            if (No_Pulse !== exp_np || Peak_Pulse !== 1'b0) begin
                errors++;
                $display("FAIL flat k=%0d: got nopulse=%b peak=%b expected nopulse=%b peak=0",
                         k, No_Pulse, Peak_Pulse, exp_np);
            end
        end
        checks++;
        if (Beat_Period !== 16'd8) begin
            errors++;
            $display("FAIL flat period hold: got %0d expected 8", Beat_Period);
        end
        for (int i = 0; i < 14; i++) begin
            feed(tri_wave[i % 8]);
            checks++;
            if (Beat_Valid !== (i == 13) || No_Pulse !== (i != 13)) begin
                errors++;
                $display("FAIL resume i=%0d: got valid=%b nopulse=%b expected valid=%b nopulse=%b",
                         i, Beat_Valid, No_Pulse, (i == 13), (i != 13));
            end
        end
        checks++;
        if (Beat_Period !== 16'd8) begin
            errors++;
            $display("FAIL resume period: got %0d expected 8", Beat_Period);
        end
    endtask

    task automatic test_boundary();
        logic [DATA_W-1:0] seq [7] = '{20'd5, 20'd0, 20'd0, 20'hFFFFF,
                                       20'hFFFF0, 20'hFFFFF, 20'hFFFF0};
        logic exp_peak [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            feed(seq[i]);
            checks++;
            if (Peak_Pulse !== exp_peak[i] || Beat_Valid !== 1'b0) begin
                errors++;
                $display("FAIL boundary step %0d: got peak=%b valid=%b expected peak=%b valid=0",
                         i, Peak_Pulse, Beat_Valid, exp_peak[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        warm_up("midreset");
        feed(20'd50);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Beat_Valid, Peak_Pulse, No_Pulse} !== 3'b000 || Beat_Period !== 16'd0) begin
            errors++;
            $display("FAIL mid reset: got valid=%b peak=%b nopulse=%b period=%0d expected all 0",
                     Beat_Valid, Peak_Pulse, No_Pulse, Beat_Period);
        end
        repeat (2) @(posedge CLK_Filter);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            feed(tri_wave[i % 8]);
            if (i == 5) begin
                checks++;
                if (Peak_Pulse !== 1'b1 || Beat_Valid !== 1'b0 || Beat_Period !== 16'd0) begin
                    errors++;
                    $display("FAIL post-reset first peak: got peak=%b valid=%b period=%0d expected 1 0 0",
                             Peak_Pulse, Beat_Valid, Beat_Period);
                end
            end
        end
        checks++;
        if (Beat_Valid !== 1'b1 || Beat_Period !== 16'd8) begin
            errors++;
            $display("FAIL post-reset second peak: got valid=%b period=%0d expected 1 8",
                     Beat_Valid, Beat_Period);
        end
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_every_other();
        test_spurious();
        test_no_pulse();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
